// File: rtl/fp_exp_align.sv
`default_nettype none
// ============================================================================
//  Module      : fp_exp_align
//  Description : Pre-add exponent alignment for two IEEE-754 binary32
//                operands. Orders the pair so the larger exponent comes
//                first, then right-shifts the smaller significand (with its
//                hidden bit) STEP bits per cycle until both share the larger
//                exponent. valid/ready handshakes on both sides.
//
//  Parameters  : STEP      - bits shifted per SHIFT cycle (1, 2, 4 or 8)
//                FLUSH_LIM - exponent difference at/above which the smaller
//                            significand is flushed to zero in one step
//
//  Ports       : clk, rst_n            - clock (rising), async active-low reset
//                in_valid/in_ready     - input handshake for A/B
//                A, B                  - binary32 operands
//                out_valid/out_ready   - output handshake
//                out_a                 - larger-exponent operand, unchanged
//                out_b                 - aligned smaller operand
//                swapped               - out_a came from B
//                out_exc               - an operand has exponent 0xFF
//                out_grs               - guard/round/sticky of the shift
//
//  Build macro : FP_EXP_ALIGN_GRS_EN - enables guard/round/sticky tracking;
//                when undefined out_grs is tied to zero.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_exp_align #(
    parameter int STEP      = 1,
    parameter int FLUSH_LIM = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        swapped,
    output logic        out_exc,
    output logic [2:0]  out_grs
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [7:0] c_step      = 8'(STEP);
    localparam logic [7:0] c_flush_lim = 8'(FLUSH_LIM);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic [31:0] r_out_a;
    logic        r_sign_s;
    logic [7:0]  r_exp_b;
    logic [23:0] r_sig_s;
    logic [7:0]  r_diff;
    logic        r_swapped;
    logic        r_exc;

    // ------------------------------------------------------------------
    // Operand ordering and classification (evaluated on the live inputs)
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_a_ge;
    logic [31:0] w_lg;
    logic [31:0] w_sm;
    logic [7:0]  w_exp_l;
    logic [7:0]  w_exp_s;
    logic [7:0]  w_diff;
    logic        w_exc;
    logic        w_flush;
    logic        w_direct;
    logic [23:0] w_sig_in;

    assign w_accept = in_valid && in_ready;
    assign w_a_ge   = (A[30:23] >= B[30:23]);          // tie keeps A first
    assign w_lg     = w_a_ge ? A : B;
    assign w_sm     = w_a_ge ? B : A;
    assign w_exp_l  = w_lg[30:23];
    assign w_exp_s  = w_sm[30:23];
    assign w_diff   = w_exp_l - w_exp_s;
    assign w_exc    = (A[30:23] == 8'hFF) || (B[30:23] == 8'hFF);
    assign w_flush  = (w_diff >= c_flush_lim);
    assign w_direct = w_exc || w_flush || (w_diff == 8'd0);
    assign w_sig_in = {(w_exp_s != 8'd0), w_sm[22:0]};  // denormals carry no hidden 1

    // Per-cycle shift amount: never overshoot the remaining difference
    logic [7:0]  w_amt;
    logic [7:0]  w_diff_nxt;
    logic [23:0] w_sig_sh;

    assign w_amt      = (r_diff < c_step) ? r_diff : c_step;
    assign w_diff_nxt = r_diff - w_amt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)                w_state_nxt = w_direct ? S_DONE : S_SHIFT;
            S_SHIFT: if (w_diff_nxt == 8'd0)      w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)               w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_a   <= 32'd0;
            r_sign_s  <= 1'b0;
            r_exp_b   <= 8'd0;
            r_sig_s   <= 24'd0;
            r_diff    <= 8'd0;
            r_swapped <= 1'b0;
            r_exc     <= 1'b0;
        end else if (w_accept) begin
            r_out_a   <= w_lg;
            r_sign_s  <= w_sm[31];
            // Exceptional pairs pass the smaller operand through untouched,
            // so it keeps its own exponent instead of adopting the larger one.
            r_exp_b   <= w_exc ? w_exp_s : w_exp_l;
            r_sig_s   <= (!w_exc && w_flush) ? 24'd0 : w_sig_in;
            r_diff    <= w_diff;
            r_swapped <= !w_a_ge;
            r_exc     <= w_exc;
        end else if (r_state == S_SHIFT) begin
            r_sig_s   <= w_sig_sh;
            r_diff    <= w_diff_nxt;
        end
    end

`ifdef FP_EXP_ALIGN_GRS_EN
    // Guard and round ride below the significand as two extra LSBs; every
    // bit that falls off the bottom of that 26-bit window joins sticky.
    logic [2:0]  r_grs;
    logic [25:0] w_ext;
    logic [25:0] w_ext_sh;
    logic [25:0] w_lost_mask;

    assign w_ext       = {r_sig_s, r_grs[2:1]};
    assign w_ext_sh    = w_ext >> w_amt;
    assign w_lost_mask = (26'd1 << w_amt) - 26'd1;
    assign w_sig_sh    = w_ext_sh[25:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grs <= 3'b000;
        end else if (w_accept) begin
            r_grs <= (!w_exc && w_flush) ? {2'b00, |w_sig_in} : 3'b000;
        end else if (r_state == S_SHIFT) begin
            r_grs <= {w_ext_sh[1:0], r_grs[0] | (|(w_ext & w_lost_mask))};
        end
    end

    assign out_grs = r_grs;
`else
    assign w_sig_sh = r_sig_s >> w_amt;
    assign out_grs  = 3'b000;
`endif

    assign out_a   = r_out_a;
    assign out_b   = {r_sign_s, r_exp_b, r_sig_s[22:0]};  // hidden bit dropped
    assign swapped = r_swapped;
    assign out_exc = r_exc;

endmodule
`default_nettype wire

// File: tb/tb_fp_exp_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_exp_align
//  Description : Self-checking bench for fp_exp_align. Directed cases plus
//                randomized operand pairs compared against an arithmetic
//                reference model of the alignment result and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_exp_align;

    localparam int TB_STEP  = 4;
    localparam int TB_FLUSH = 25;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] A         = 32'd0;
    logic [31:0] B         = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        swapped;
    logic        out_exc;
    logic [2:0]  out_grs;

    fp_exp_align #(
        .STEP      (TB_STEP),
        .FLUSH_LIM (TB_FLUSH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .swapped   (swapped),
        .out_exc   (out_exc),
        .out_grs   (out_grs)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: the aligned result is simply the smaller significand
    // divided by 2^diff; guard/round/sticky are read straight off the
    // discarded bits of the unshifted significand.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ea, output logic [31:0] eb,
                                  output logic esw, output logic eexc,
                                  output logic [2:0] egrs, output int elat);
        logic [31:0] lg;
        logic [31:0] sm;
        logic [63:0] sig;
        logic [63:0] sh;
        int          d;
        esw  = (b[30:23] > a[30:23]);
        lg   = esw ? b : a;
        sm   = esw ? a : b;
        d    = int'(lg[30:23]) - int'(sm[30:23]);
        eexc = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        sig  = {40'd0, (sm[30:23] != 8'd0), sm[22:0]};
        ea   = lg;
        egrs = 3'b000;
        if (eexc) begin
            eb   = sm;
            elat = 1;
        end else if (d >= TB_FLUSH) begin
            eb   = {sm[31], lg[30:23], 23'd0};
            egrs = {2'b00, (sig != 64'd0)};
            elat = 1;
        end else begin
            sh = sig / (64'd1 << d);
            eb = {sm[31], lg[30:23], sh[22:0]};
            if (d >= 1) egrs[2] = sig[d-1];
            if (d >= 2) egrs[1] = sig[d-2];
            if (d >= 3) egrs[0] = ((sig % (64'd1 << (d-2))) != 64'd0);
            elat = 1 + (d + TB_STEP - 1) / TB_STEP;
        end
`ifndef FP_EXP_ALIGN_GRS_EN
        egrs = 3'b000;
`endif
    endfunction

    // Enter and leave at a falling edge.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit poke, input string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        logic        esw;
        logic        eexc;
        logic [2:0]  egrs;
        int          elat;
        int          lat;
        int          guard;
        model(a, b, ea, eb, esw, eexc, egrs, elat);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = $urandom; B = $urandom;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, elat);
        check({tag, "_out_a"},   out_a, ea);
        check({tag, "_out_b"},   out_b, eb);
        check({tag, "_swapped"}, swapped, esw);
        check({tag, "_exc"},     out_exc, eexc);
        check({tag, "_grs"},     out_grs, egrs);
        check({tag, "_busy"},    in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1; A = $urandom; B = $urandom;
            end
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_out_a"}, out_a, ea);
            check({tag, "_hold_out_b"}, out_b, eb);
            check({tag, "_hold_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_a",     out_a, 0);
        check("rst_out_b",     out_b, 0);
        check("rst_swapped",   swapped, 0);
        check("rst_exc",       out_exc, 0);
        check("rst_grs",       out_grs, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(32'h40000000, 32'h3F800000, 0, 1'b0, "diff1");
        run_txn(32'h3F800000, 32'h40400000, 0, 1'b0, "swap");
        run_txn(32'h3FC00000, 32'h3F800000, 0, 1'b0, "equal");
        run_txn(32'h4C000000, 32'h3F800001, 0, 1'b0, "flush25");
        run_txn(32'h4B800000, 32'hBF812345, 0, 1'b0, "diff24");
        run_txn(32'h41800000, 32'h3F800000, 5, 1'b1, "diff4_hold");
        run_txn(32'h7FC00000, 32'h3F800000, 0, 1'b0, "nan");
        run_txn(32'h3F800000, 32'hFF800000, 0, 1'b0, "ninf_b");
        run_txn(32'h00800000, 32'h00400001, 0, 1'b0, "denorm");
        run_txn(32'h4A7FFFFF, 32'h3FFFFFFF, 1, 1'b0, "diff21");

        // Reset while the shift is in progress
        A = 32'h4A000000; B = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready",  in_ready, 1);
        check("abort_out_a",     out_a, 0);
        check("abort_out_b",     out_b, 0);
        check("abort_swapped",   swapped, 0);
        check("abort_exc",       out_exc, 0);
        check("abort_grs",       out_grs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 6))
                0:       rb[30:23] = ra[30:23];
                1, 2:    rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
                3:       ra[30:23] = rb[30:23] - 8'($urandom_range(0, 30));
                4:       ra[30:23] = 8'hFF;
                5: begin
                    rb[30:23] = 8'h00;
                    ra[30:23] = 8'($urandom_range(0, 20));
                end
                default: ;
            endcase
            run_txn(ra, rb, int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
